// File: rtl/tsic_pkg.sv
// rtl/tsic_pkg.sv - shared widths and averaging state encoding for the PTAT front end
package tsic_pkg;
    localparam int A2D_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } avg_state_t;
endpackage

// File: rtl/a2d_avg.sv
// rtl/a2d_avg.sv - averages 2^LOG2_N PTAT_A2D conversions per strt request
// Optional A2D_AVG_ROUND_EN: round-to-nearest with saturation instead of truncation.
module a2d_avg
    import tsic_pkg::*;
#(
    parameter int LOG2_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt,
    output logic             cmplt,
    output logic [A2D_W-1:0] avg,
    output logic             a2d_strt,
    input  logic             a2d_cmplt,
    input  logic [A2D_W-1:0] a2d
);
    localparam int ACC_W = A2D_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int LAST  = (1 << LOG2_N) - 1;

    avg_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [A2D_W-1:0] avg_q, avg_d;
    logic             cmplt_q, cmplt_d;
    logic             a2d_strt_q, a2d_strt_d;
    logic [A2D_W-1:0] result;

`ifdef A2D_AVG_ROUND_EN
    // Half-LSB addend; (1<<0)>>1 yields 0 so a single sample passes through unchanged.
    localparam int HALF = (1 << LOG2_N) >> 1;
    logic [ACC_W:0] rsum;
    logic [ACC_W:0] rshift;

    always_comb begin
        rsum   = {1'b0, acc_q} + (ACC_W+1)'(HALF);
        rshift = rsum >> LOG2_N;
        result = (rshift > (ACC_W+1)'((1 << A2D_W) - 1)) ? {A2D_W{1'b1}}
                                                         : rshift[A2D_W-1:0];
    end
`else
    assign result = A2D_W'(acc_q >> LOG2_N);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        case (state_q)
            IDLE: begin
                if (strt) begin
                    state_d = CONV;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: state_d = WAIT;
            WAIT: begin
                if (a2d_cmplt) begin
                    acc_d   = acc_q + ACC_W'(a2d);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q < CNT_W'(LAST)) ? CONV : DONE;
                end
            end
            DONE: begin
                avg_d   = result;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered pulses: a2d_strt coincides with CONV, cmplt/avg land the cycle after DONE.
        a2d_strt_d = (state_d == CONV);
        cmplt_d    = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            avg_q      <= '0;
            cmplt_q    <= 1'b0;
            a2d_strt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            avg_q      <= avg_d;
            cmplt_q    <= cmplt_d;
            a2d_strt_q <= a2d_strt_d;
        end
    end

    assign cmplt    = cmplt_q;
    assign avg      = avg_q;
    assign a2d_strt = a2d_strt_q;
endmodule

// File: tb/tb_a2d_avg.sv
// tb/tb_a2d_avg.sv - randomized self-checking bench for a2d_avg (LOG2_N=3 and LOG2_N=0 instances)
module tb_a2d_avg;
    localparam int LN0 = 3;
    localparam int LN1 = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  strt, a2d_cmplt, cmplt, a2d_strt;
    logic [11:0] a2d [2];
    logic [11:0] avg [2];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          smp [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    a2d_avg #(.LOG2_N(LN0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .strt(strt[0]), .cmplt(cmplt[0]), .avg(avg[0]),
        .a2d_strt(a2d_strt[0]), .a2d_cmplt(a2d_cmplt[0]), .a2d(a2d[0])
    );

    a2d_avg #(.LOG2_N(LN1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .strt(strt[1]), .cmplt(cmplt[1]), .avg(avg[1]),
        .a2d_strt(a2d_strt[1]), .a2d_cmplt(a2d_cmplt[1]), .a2d(a2d[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mean of the first n entries of smp, computed arithmetically.
    function automatic int ref_avg(input int n);
        int sum;
        int r;
        sum = 0;
        for (int i = 0; i < n; i++) sum += smp[i];
`ifdef A2D_AVG_ROUND_EN
        r = (sum + n / 2) / n;
        if (r > 4095) r = 4095;
`else
        r = sum / n;
`endif
        return r;
    endfunction

    task automatic do_request(input int idx, input int lg, input bit extra, input string tag);
        int n, exp_avg, starts, dones, got, t0, t_last, t_done, delay, guard;
        n = 1 << lg;
        exp_avg = ref_avg(n);
        starts = 0; dones = 0; got = 0; t_last = 0; t_done = -1; delay = 0; guard = 0;
        @(negedge clk);
        strt[idx] = 1'b1;
        a2d_cmplt[idx] = 1'b1;
        a2d[idx] = 12'($urandom);
        t0 = cyc;
        while (guard < 500) begin
            @(negedge clk);
            guard++;
            strt[idx] = 1'b0;
            a2d_cmplt[idx] = 1'b0;
            a2d[idx] = 12'($urandom);
            if (got == n && t_done >= 0 && cyc >= t_done + 4) break;
            if (a2d_strt[idx]) begin
                starts++;
                if (starts == 1) check({tag, " strt_lat"}, cyc - t0, 1);
                delay = (extra && starts == 4) ? 3 : int'($urandom_range(1, 4));
            end else if (delay > 0) begin
                delay--;
                if (extra && starts == 4 && delay == 2) strt[idx] = 1'b1;
                if (delay == 0 && got < n) begin
                    a2d_cmplt[idx] = 1'b1;
                    a2d[idx] = 12'(smp[got]);
                    got++;
                    t_last = cyc;
                end
            end
            if (cmplt[idx]) begin
                dones++;
                t_done = cyc;
                check({tag, " cmplt_lat"}, cyc - t_last, 2);
                check({tag, " avg"}, int'(avg[idx]), exp_avg);
            end
            if (t_done >= 0 && cyc == t_done + 1) a2d_cmplt[idx] = 1'b1;
        end
        check({tag, " finished"}, int'(t_done >= 0), 1);
        check({tag, " a2d_strt_cnt"}, starts, n);
        check({tag, " cmplt_cnt"}, dones, 1);
        check({tag, " avg_hold"}, int'(avg[idx]), exp_avg);
    endtask

    task automatic reset_mid();
        int starts, guard, bad_c, bad_s;
        bit pend;
        starts = 0; guard = 0; bad_c = 0; bad_s = 0; pend = 1'b0;
        @(negedge clk);
        strt[0] = 1'b1;
        while (starts < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            strt[0] = 1'b0;
            a2d_cmplt[0] = 1'b0;
            if (pend) begin
                a2d_cmplt[0] = 1'b1;
                a2d[0] = 12'($urandom);
                pend = 1'b0;
            end
            if (a2d_strt[0]) begin
                starts++;
                pend = (starts < 4);
            end
        end
        check("rst reached_4th", starts, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst cmplt", int'(cmplt[0]), 0);
        check("rst a2d_strt", int'(a2d_strt[0]), 0);
        check("rst avg", int'(avg[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a2d_cmplt[0] = 1'b1;
        a2d[0] = 12'h7FF;
        repeat (10) begin
            @(negedge clk);
            a2d_cmplt[0] = 1'b0;
            if (cmplt[0]) bad_c++;
            if (a2d_strt[0]) bad_s++;
        end
        check("rst late_cmplt", bad_c, 0);
        check("rst late_a2d_strt", bad_s, 0);
        check("rst avg_after", int'(avg[0]), 0);
    endtask

    initial begin
        strt = '0;
        a2d_cmplt = '0;
        a2d[0] = '0;
        a2d[1] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset avg", int'(avg[k]), 0);
            check("reset cmplt", int'(cmplt[k]), 0);
            check("reset a2d_strt", int'(a2d_strt[k]), 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) smp[i] = 'h100;
        do_request(0, LN0, 1'b0, "flat100");
        for (int i = 0; i < 8; i++) smp[i] = (i == 7) ? 4 : 0;
        do_request(0, LN0, 1'b0, "small");
        for (int i = 0; i < 8; i++) smp[i] = 'hFFF;
        do_request(0, LN0, 1'b0, "allfff");
        for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 4095));
        do_request(0, LN0, 1'b1, "extra_strt");
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 4095));
            do_request(0, LN0, 1'b0, "rand8");
        end
        for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(4080, 4095));
        do_request(0, LN0, 1'b0, "high8");

        reset_mid();
        for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 4095));
        do_request(0, LN0, 1'b0, "after_rst");

        smp[0] = 'h5A3;
        do_request(1, LN1, 1'b0, "single");
        for (int r = 0; r < 3; r++) begin
            smp[0] = int'($urandom_range(0, 4095));
            do_request(1, LN1, 1'b0, "rand1");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
